// File: rtl/device_router_if.sv
// SPI link into device_router: serial clock, chip select and the two data
// lines. "do" is a reserved word in SystemVerilog, so MISO is carried as dout.
interface device_router_if;
  logic sclk;
  logic ncs;
  logic di;
  logic dout;

  modport master (
    output sclk,
    output ncs,
    output di,
    input  dout
  );

  modport slave (
    input  sclk,
    input  ncs,
    input  di,
    output dout
  );
endinterface

// File: rtl/device_router.sv
// device_router: SPI (mode 0) slave that routes per-channel GPIO pad
// outputs/enables and I2C open-drain enables, and reads back pad levels.
// Transaction: byte0 = channel, byte1 = command, byte2 = data (write) or
// the byte shifted out on dout (read). All SPI inputs are oversampled in clk.
module device_router #(
  parameter int CHANNELS = 3,
  parameter int IO_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         nreset,
  device_router_if.slave               spi,
  input  logic [CHANNELS*IO_WIDTH-1:0] module_in,
  output logic [CHANNELS*IO_WIDTH-1:0] module_out,
  output logic [CHANNELS*IO_WIDTH-1:0] module_oe,
  input  logic [CHANNELS-1:0]          sda_in,
  input  logic [CHANNELS-1:0]          scl_in,
  output logic [CHANNELS-1:0]          sda_oe,
  output logic [CHANNELS-1:0]          scl_oe
);

  localparam int PW = CHANNELS * IO_WIDTH;

  localparam logic [2:0] CMD_WR_OUT = 3'd1;
  localparam logic [2:0] CMD_WR_OE  = 3'd2;
  localparam logic [2:0] CMD_RD_IN  = 3'd3;
  localparam logic [2:0] CMD_WR_I2C = 3'd4;
  localparam logic [2:0] CMD_RD_I2C = 3'd5;
  localparam logic [2:0] CMD_RD_OUT = 3'd6;
  localparam logic [2:0] CMD_RD_OE  = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CHAN = 3'd1,
    CMD  = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------
  logic [1:0]          sclk_sync;
  logic [1:0]          ncs_sync;
  logic [1:0]          di_sync;
  logic [PW-1:0]       in_meta;
  logic [PW-1:0]       in_sync;
  logic [CHANNELS-1:0] sda_meta;
  logic [CHANNELS-1:0] sda_sync;
  logic [CHANNELS-1:0] scl_meta;
  logic [CHANNELS-1:0] scl_sync;
  logic                sclk_prev;

  logic sclk_s;
  logic ncs_s;
  logic di_s;
  logic sclk_rise;

  // Two-flop synchronizers; reset values are the idle bus levels
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sclk_sync <= 2'b00;
      ncs_sync  <= 2'b11;
      di_sync   <= 2'b11;
      in_meta   <= '0;
      in_sync   <= '0;
      sda_meta  <= '1;
      sda_sync  <= '1;
      scl_meta  <= '1;
      scl_sync  <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi.sclk};
      ncs_sync  <= {ncs_sync[0], spi.ncs};
      di_sync   <= {di_sync[0], spi.di};
      in_meta   <= module_in;
      in_sync   <= in_meta;
      sda_meta  <= sda_in;
      sda_sync  <= sda_meta;
      scl_meta  <= scl_in;
      scl_sync  <= scl_meta;
      sclk_prev <= sclk_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign ncs_s     = ncs_sync[1];
  assign di_s      = di_sync[1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // ---------------------------------------------------------------------
  // Arming: after reset, a transaction may only start once a genuine ncs
  // high has been observed. The flush register ignores the synchronizer's
  // reset value of ncs, which is not a real sample of the pin.
  // ---------------------------------------------------------------------
  logic [1:0] flush_reg;
  logic       armed_reg;

  // Track synchronizer flush and arm on the first real ncs high
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      flush_reg <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      flush_reg <= {flush_reg[0], 1'b1};
      if (flush_reg[1] && ncs_s) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shift datapath and control registers
  // ---------------------------------------------------------------------
  state_t              state_reg;
  state_t              state_next;
  logic [2:0]          bit_cnt_reg;
  logic [7:0]          rx_reg;
  logic [7:0]          tx_reg;
  logic [3:0]          chan_reg;
  logic [2:0]          cmd_reg;
  logic                wr_pend_reg;
  logic [IO_WIDTH-1:0] wr_data_reg;
  logic [1:0]          wr_i2c_reg;

  logic       shifting;
  logic       shift_en;
  logic       byte_done;
  logic [7:0] rx_byte;
  logic       cmd_valid;
  logic       new_cmd_read;
  logic       cur_cmd_read;
  logic       cur_cmd_write;
  logic       chan_ok;
  logic [7:0] rd_val;

  assign shifting  = (state_reg == CHAN) || (state_reg == CMD) || (state_reg == DATA);
  assign shift_en  = sclk_rise && shifting && !ncs_s;
  assign byte_done = shift_en && (bit_cnt_reg == 3'd7);
  assign rx_byte   = {rx_reg[6:0], di_s};
  assign chan_ok   = rx_byte < 8'(CHANNELS);
  assign cmd_valid = (rx_byte != 8'h00) && (rx_byte <= 8'h07);

  assign new_cmd_read  = (rx_byte[2:0] == CMD_RD_IN)  || (rx_byte[2:0] == CMD_RD_I2C) ||
                         (rx_byte[2:0] == CMD_RD_OUT) || (rx_byte[2:0] == CMD_RD_OE);
  assign cur_cmd_read  = (cmd_reg == CMD_RD_IN)  || (cmd_reg == CMD_RD_I2C) ||
                         (cmd_reg == CMD_RD_OUT) || (cmd_reg == CMD_RD_OE);
  assign cur_cmd_write = (cmd_reg == CMD_WR_OUT) || (cmd_reg == CMD_WR_OE) ||
                         (cmd_reg == CMD_WR_I2C);

  // Read-back value for the latched channel and the command in rx_byte
  always_comb begin
    rd_val = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan_reg == 4'(c)) begin
        case (rx_byte[2:0])
          CMD_RD_IN:  rd_val = 8'(in_sync[c*IO_WIDTH +: IO_WIDTH]);
          CMD_RD_I2C: rd_val = {4'b0000, scl_oe[c], sda_oe[c], scl_sync[c], sda_sync[c]};
          CMD_RD_OUT: rd_val = 8'(module_out[c*IO_WIDTH +: IO_WIDTH]);
          CMD_RD_OE:  rd_val = 8'(module_oe[c*IO_WIDTH +: IO_WIDTH]);
          default:    rd_val = 8'h00;
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; ncs high always wins and aborts the transaction
  always_comb begin
    state_next = state_reg;
    if (ncs_s) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (armed_reg) state_next = CHAN;
        CHAN: if (byte_done) state_next = chan_ok ? CMD : ERR;
        CMD:  if (byte_done) state_next = cmd_valid ? DATA : ERR;
        DATA: if (byte_done) state_next = DONE;
        DONE: state_next = DONE;
        ERR:  state_next = ERR;
        default: state_next = IDLE;
      endcase
    end
  end

  // Bit counter, RX/TX shifters, channel/command latches, write request
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bit_cnt_reg <= 3'd0;
      rx_reg      <= 8'hFF;
      tx_reg      <= 8'hFF;
      chan_reg    <= 4'd0;
      cmd_reg     <= 3'd0;
      wr_pend_reg <= 1'b0;
      wr_data_reg <= '0;
      wr_i2c_reg  <= 2'b00;
    end else begin
      wr_pend_reg <= 1'b0;
      if (ncs_s) begin
        bit_cnt_reg <= 3'd0;
        rx_reg      <= 8'hFF;
        tx_reg      <= 8'hFF;
      end else if (shift_en) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        rx_reg      <= rx_byte;
        if (state_reg == DATA) begin
          tx_reg <= {tx_reg[6:0], 1'b1};
        end
        if (byte_done) begin
          case (state_reg)
            CHAN: if (chan_ok) chan_reg <= rx_byte[3:0];
            CMD: begin
              if (cmd_valid) begin
                cmd_reg <= rx_byte[2:0];
                if (new_cmd_read) begin
                  tx_reg <= rd_val;
                end
              end
            end
            DATA: begin
              if (cur_cmd_write) begin
                wr_pend_reg <= 1'b1;
                wr_data_reg <= rx_byte[IO_WIDTH-1:0];
                wr_i2c_reg  <= rx_byte[1:0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // MISO idles high; it only carries data during the data byte of a read
  assign spi.dout = ((state_reg == DATA) && cur_cmd_read) ? tx_reg[7] : 1'b1;

  // ---------------------------------------------------------------------
  // Per-channel output registers; only the addressed channel updates
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [IO_WIDTH-1:0] out_q;
    logic [IO_WIDTH-1:0] oe_q;
    logic                sda_q;
    logic                scl_q;
    logic                hit;

    assign hit = wr_pend_reg && (chan_reg == 4'(gi));

    // Commit a pending write to this channel's target register
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        out_q <= '0;
        oe_q  <= '0;
        sda_q <= 1'b0;
        scl_q <= 1'b0;
      end else if (hit) begin
        case (cmd_reg)
          CMD_WR_OUT: out_q <= wr_data_reg;
          CMD_WR_OE:  oe_q  <= wr_data_reg;
          CMD_WR_I2C: begin
            sda_q <= wr_i2c_reg[0];
            scl_q <= wr_i2c_reg[1];
          end
          default: ;
        endcase
      end
    end

    assign module_out[gi*IO_WIDTH +: IO_WIDTH] = out_q;
    assign module_oe[gi*IO_WIDTH +: IO_WIDTH]  = oe_q;
    assign sda_oe[gi] = sda_q;
    assign scl_oe[gi] = scl_q;
  end

endmodule

// File: tb/tb_device_router.sv
// Bench for device_router: table of SPI transactions with expected read byte
// and pad state, a read-byte scoreboard queue, and hand sequences for abort,
// capture timing and mid-transaction reset.
module tb_device_router;
  localparam int CH   = 3;
  localparam int IOW  = 6;
  localparam int PW   = CH * IOW;
  localparam int HALF = 80;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic [PW-1:0] module_in;
  logic [PW-1:0] module_out;
  logic [PW-1:0] module_oe;
  logic [CH-1:0] sda_in;
  logic [CH-1:0] scl_in;
  logic [CH-1:0] sda_oe;
  logic [CH-1:0] scl_oe;

  device_router_if spi ();

  device_router #(.CHANNELS(CH), .IO_WIDTH(IOW)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .spi        (spi),
    .module_in  (module_in),
    .module_out (module_out),
    .module_oe  (module_oe),
    .sda_in     (sda_in),
    .scl_in     (scl_in),
    .sda_oe     (sda_oe),
    .scl_oe     (scl_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
    logic [PW-1:0] min;
    logic [CH-1:0] sda_i;
    logic [CH-1:0] scl_i;
    logic [7:0]    exp_rd;
    logic [PW-1:0] exp_out;
    logic [PW-1:0] exp_oe;
    logic [CH-1:0] exp_sda;
    logic [CH-1:0] exp_scl;
  } vec_t;

  vec_t       vt [16];
  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Clock n bits of b out MSB first; r collects dout sampled just before each rise
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'hFF;
    for (int i = 0; i < n; i++) begin
      spi.di = b[7-i];
      #HALF;
      r = {r[6:0], spi.dout};
      spi.sclk = 1'b1;
      #HALF;
      spi.sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      output logic [7:0] r);
    logic [7:0] junk;
    spi.ncs = 1'b0;
    #HALF;
    spi_bits(b0, 8, junk);
    spi_bits(b1, 8, junk);
    spi_bits(b2, 8, r);
    #HALF;
    spi.ncs = 1'b1;
    #(2*HALF);
    $display("xfer %h %h %h -> read %h", b0, b1, b2, r);
  endtask

  // Pop the expected read byte and compare with what was shifted out
  task automatic score(input string name, input logic [7:0] got);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h, expected queue empty", name, got);
    end else begin
      exp = exp_q.pop_front();
      check(name, 32'(got), 32'(exp));
    end
  endtask

  task automatic check_pads(input string tag, input logic [PW-1:0] eo, input logic [PW-1:0] ee,
                            input logic [CH-1:0] es, input logic [CH-1:0] ec);
    check({tag, " module_out"}, 32'(module_out), 32'(eo));
    check({tag, " module_oe"},  32'(module_oe),  32'(ee));
    check({tag, " sda_oe"},     32'(sda_oe),     32'(es));
    check({tag, " scl_oe"},     32'(scl_oe),     32'(ec));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] junk;

    //          b0     b1     b2     module_in  sda_i   scl_i   rd     out        oe         sda     scl
    vt[0]  = '{8'h01, 8'h02, 8'h2A, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h00000, 18'h00A80, 3'b000, 3'b000};
    vt[1]  = '{8'h00, 8'h01, 8'h3F, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h0003F, 18'h00A80, 3'b000, 3'b000};
    vt[2]  = '{8'h02, 8'h01, 8'h15, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h1503F, 18'h00A80, 3'b000, 3'b000};
    vt[3]  = '{8'h02, 8'h06, 8'h00, 18'h00000, 3'b111, 3'b111, 8'h15, 18'h1503F, 18'h00A80, 3'b000, 3'b000};
    vt[4]  = '{8'h01, 8'h07, 8'h00, 18'h00000, 3'b111, 3'b111, 8'h2A, 18'h1503F, 18'h00A80, 3'b000, 3'b000};
    vt[5]  = '{8'h00, 8'h03, 8'h00, 18'h00015, 3'b111, 3'b111, 8'h15, 18'h1503F, 18'h00A80, 3'b000, 3'b000};
    vt[6]  = '{8'h01, 8'h03, 8'h00, 18'h009C0, 3'b111, 3'b111, 8'h27, 18'h1503F, 18'h00A80, 3'b000, 3'b000};
    vt[7]  = '{8'h03, 8'h01, 8'hFF, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h1503F, 18'h00A80, 3'b000, 3'b000};
    vt[8]  = '{8'h01, 8'h09, 8'h3F, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h1503F, 18'h00A80, 3'b000, 3'b000};
    vt[9]  = '{8'h01, 8'h01, 8'hFF, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h15FFF, 18'h00A80, 3'b000, 3'b000};
    vt[10] = '{8'h02, 8'h04, 8'h03, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h15FFF, 18'h00A80, 3'b100, 3'b100};
    vt[11] = '{8'h02, 8'h05, 8'h00, 18'h00000, 3'b011, 3'b100, 8'h0E, 18'h15FFF, 18'h00A80, 3'b100, 3'b100};
    vt[12] = '{8'h00, 8'h04, 8'h02, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h15FFF, 18'h00A80, 3'b100, 3'b101};
    vt[13] = '{8'h00, 8'h05, 8'h00, 18'h00000, 3'b001, 3'b000, 8'h09, 18'h15FFF, 18'h00A80, 3'b100, 3'b101};
    vt[14] = '{8'h01, 8'h02, 8'h00, 18'h00000, 3'b111, 3'b111, 8'hFF, 18'h15FFF, 18'h00000, 3'b100, 3'b101};
    vt[15] = '{8'h02, 8'h03, 8'h00, 18'h2B000, 3'b111, 3'b111, 8'h2B, 18'h15FFF, 18'h00000, 3'b100, 3'b101};

    spi.sclk  = 1'b0;
    spi.ncs   = 1'b1;
    spi.di    = 1'b1;
    module_in = '0;
    sda_in    = '1;
    scl_in    = '1;

    // Reset state, sampled while nreset is still low
    #32;
    check_pads("reset", '0, '0, '0, '0);
    check("reset dout", 32'(spi.dout), 32'd1);
    #20;
    nreset = 1'b1;
    #100;

    // Table-driven transactions
    for (int i = 0; i < 16; i++) begin
      module_in = vt[i].min;
      sda_in    = vt[i].sda_i;
      scl_in    = vt[i].scl_i;
      exp_q.push_back(vt[i].exp_rd);
      xfer(vt[i].b0, vt[i].b1, vt[i].b2, rd);
      score($sformatf("vec%0d read", i), rd);
      check_pads($sformatf("vec%0d", i), vt[i].exp_out, vt[i].exp_oe, vt[i].exp_sda, vt[i].exp_scl);
    end
    sda_in = '1;
    scl_in = '1;

    // Read IN returns the value captured at the command byte, not later pin values
    module_in = 18'h0002A;
    exp_q.push_back(8'h2A);
    spi.ncs = 1'b0;
    #HALF;
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h03, 8, junk);
    module_in = 18'h00015;
    spi_bits(8'h00, 8, rd);
    #HALF;
    spi.ncs = 1'b1;
    #(2*HALF);
    $display("xfer 00 03 00 (pins changed mid-read) -> read %h", rd);
    score("capture read", rd);

    // Abort after 4 bits of the data byte: no write
    spi.ncs = 1'b0;
    #HALF;
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h01, 8, junk);
    spi_bits(8'h00, 4, junk);
    spi.ncs = 1'b1;
    #(2*HALF);
    $display("xfer 00 01 (4 bits, aborted)");
    check("abort module_out", 32'(module_out), 32'h15FFF);
    exp_q.push_back(8'hFF);
    xfer(8'h00, 8'h01, 8'h0A, rd);
    score("after abort read", rd);
    check("after abort module_out", 32'(module_out), 32'h15FCA);

    // Reset pulse in the middle of the data byte
    spi.ncs = 1'b0;
    #HALF;
    spi_bits(8'h01, 8, junk);
    spi_bits(8'h02, 8, junk);
    spi_bits(8'h3F, 4, junk);
    nreset = 1'b0;
    #1;
    check_pads("mid reset", '0, '0, '0, '0);
    check("mid reset dout", 32'(spi.dout), 32'd1);
    #19;
    nreset = 1'b1;
    #HALF;
    // ncs never went high: the rest of this frame and a whole new one are ignored
    spi_bits(8'h3F, 4, junk);
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h01, 8, junk);
    spi_bits(8'h3F, 8, junk);
    #HALF;
    spi.ncs = 1'b1;
    #(2*HALF);
    $display("xfer after reset release with ncs held low");
    check_pads("post reset", '0, '0, '0, '0);
    exp_q.push_back(8'hFF);
    xfer(8'h00, 8'h01, 8'h07, rd);
    score("post reset write read", rd);
    check("post reset module_out", 32'(module_out), 32'h00007);
    exp_q.push_back(8'h07);
    xfer(8'h00, 8'h06, 8'h00, rd);
    score("post reset read back", rd);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/device_router.md
DEVICE_ROUTER -- requirements
Module: device_router

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 3, number of module channels served (1..16).
REQ-002 The block SHALL have parameter IO_WIDTH, default 6, GPIO pins per channel (1..8).
REQ-003 The block SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 The block SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port sclk  input  1  SPI clock (mode 0), asynchronous to clk.
REQ-006 The block SHALL have port ncs  input  1  SPI chip select, active-low, asynchronous.
REQ-007 The block SHALL have port di  input  1  SPI MOSI, MSB first.
REQ-008 The block SHALL have port do  output  1  SPI MISO; idle high so it can be wired-AND with other slaves.
REQ-009 The block SHALL have port module_in  input  CHANNELS*IO_WIDTH  pad input values; channel c occupies bits [c*IO_WIDTH +: IO_WIDTH].
REQ-010 The block SHALL have port module_out  output  CHANNELS*IO_WIDTH  pad output values, same packing.
REQ-011 The block SHALL have port module_oe  output  CHANNELS*IO_WIDTH  pad output enables, 1 = drive, same packing.
REQ-012 The block SHALL have ports sda_in, scl_in  input  CHANNELS  I2C pad levels, one bit per channel.
REQ-013 The block SHALL have ports sda_oe, scl_oe  output  CHANNELS  open-drain pull-low enables, one bit per channel.

Function
REQ-014 sclk, ncs, di, module_in, sda_in and scl_in SHALL each pass through a 2-flop synchronizer before use; sclk rising edges SHALL be detected from the synchronized value.
REQ-015 Correct operation SHALL be guaranteed for sclk high and low phases each of at least 4 clk periods.
REQ-016 The state machine SHALL have states IDLE, CHAN, CMD, DATA, DONE, ERR.
REQ-017 Synchronized ncs high SHALL force IDLE within 1 clk, clear the bit counter and discard any partial byte; no register write SHALL occur.
REQ-018 On ncs low in IDLE, the machine SHALL enter CHAN; each sclk rising edge SHALL shift di into an 8-bit RX register (MSB first) and increment a 3-bit bit counter that wraps 7->0.
REQ-019 On counter wrap in CHAN, byte0 SHALL be latched as channel index; index >= CHANNELS SHALL go to ERR; otherwise the machine SHALL go to CMD.
REQ-020 On counter wrap in CMD, byte1 SHALL be decoded: 0x01 write OUT, 0x02 write OE, 0x03 read IN, 0x04 write I2C, 0x05 read I2C, 0x06 read OUT, 0x07 read OE; any other value SHALL go to ERR; valid commands SHALL go to DATA.
REQ-021 For read commands, the TX register SHALL be loaded in the same clk as the byte1 wrap. Value: selected channel's field, zero-extended to 8 bits. For 0x05 the value SHALL be {4'b0, scl_oe, sda_oe, scl_in, sda_in}.
REQ-022 do SHALL equal TX[7] while in DATA for a read; TX SHALL shift left (filling 1) on each sclk rising edge.
REQ-023 do SHALL be 1 in IDLE, CHAN, CMD, DONE, ERR and during write commands.
REQ-024 For write commands, on byte2 wrap the target register SHALL update 1 clk later. Writes use the low IO_WIDTH bits; 0x04 uses bit0 -> sda_oe[c] and bit1 -> scl_oe[c]. Only channel c SHALL change.
REQ-025 After byte2 wrap, the machine SHALL enter DONE and ignore further sclk edges until ncs rises.
REQ-026 ERR SHALL ignore all sclk edges and perform no writes until ncs rises.
REQ-027 Read IN SHALL return the synchronized pin value captured at the byte1 wrap; later pin changes SHALL NOT alter the byte being shifted.

Reset
REQ-028 While nreset low, asynchronously: state IDLE, counters 0, RX/TX 0xFF, module_out 0, module_oe 0, sda_oe 0, scl_oe 0, do 1, synchronizers at idle levels (ncs 1, sclk 0).
REQ-029 Reset release mid-transaction SHALL leave the block in IDLE until ncs is seen high and then low again.

Verification
REQ-030 Bench: reset, then ncs low, bytes 0x01,0x02,0x2A, ncs high -> module_oe[11:6]=6'h2A; all other oe bits 0.
REQ-031 Bench: module_in[5:0]=6'h15, send 0x00,0x03,0x00 -> do shifts 0x15 MSB first during byte2.
REQ-032 Bench: send 0x03 (CHANNELS=3) then 0x01,0xFF -> ERR, do stays 1, no output changes.
REQ-033 Bench: send 0x02,0x04,0x03, then 0x02,0x05,0x00 with scl_in[2]=1 and sda_in[2]=0 -> sda_oe[2]=1, scl_oe[2]=1; read byte 0x0E.
REQ-034 Bench: ncs high after 4 bits of byte2 of write 0x00,0x01 -> module_out unchanged; next full transaction succeeds.
REQ-035 Bench: nreset pulsed low mid-byte2 -> all outputs return to REQ-028 values immediately.
